// File: rtl/p_mul_arbiter.sv
// Arbitrates two requesters onto one shared p_mul instance and holds the grant until the multiply completes.
// Optional macro P_MUL_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module p_mul_arbiter #(
  parameter int XLEN = 32,
  parameter int PW_W = 5
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            rq0_valid,
  output logic            rq0_ready,
  input  logic            rq0_mul_l,
  input  logic            rq0_mul_h,
  input  logic            rq0_clmul,
  input  logic [PW_W-1:0] rq0_pw,
  input  logic [XLEN-1:0] rq0_crs1,
  input  logic [XLEN-1:0] rq0_crs2,
  output logic [XLEN-1:0] rq0_result,
  input  logic            rq1_valid,
  output logic            rq1_ready,
  input  logic            rq1_mul_l,
  input  logic            rq1_mul_h,
  input  logic            rq1_clmul,
  input  logic [PW_W-1:0] rq1_pw,
  input  logic [XLEN-1:0] rq1_crs1,
  input  logic [XLEN-1:0] rq1_crs2,
  output logic [XLEN-1:0] rq1_result,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic            mul_mul_l,
  output logic            mul_mul_h,
  output logic            mul_clmul,
  output logic [PW_W-1:0] mul_pw,
  output logic [XLEN-1:0] mul_crs1,
  output logic [XLEN-1:0] mul_crs2,
  input  logic [XLEN-1:0] mul_result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   busy_q, busy_d;

  // Next-state: arbitrate in IDLE, release on completion or when the granted valid drops.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (rq0_valid && rq1_valid) begin
`ifdef P_MUL_ARB_FIXED_PRIO_EN
          state_d = GNT0;
`else
          state_d = last_q ? GNT0 : GNT1;
`endif
        end else if (rq0_valid) begin
          state_d = GNT0;
        end else if (rq1_valid) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!rq0_valid) begin
          state_d = IDLE;
        end else if (mul_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else begin
          state_d = GNT0;
        end
      end
      GNT1: begin
        if (!rq1_valid) begin
          state_d = IDLE;
        end else if (mul_ready) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else begin
          state_d = GNT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Arbiter state, round-robin pointer and busy flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Operands are not registered: the granted requester holds them stable until ready.
  always_comb begin
    mul_valid = 1'b0;
    mul_mul_l = 1'b0;
    mul_mul_h = 1'b0;
    mul_clmul = 1'b0;
    mul_pw    = {PW_W{1'b0}};
    mul_crs1  = {XLEN{1'b0}};
    mul_crs2  = {XLEN{1'b0}};
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    case (state_q)
      GNT0: begin
        mul_valid = rq0_valid;
        mul_mul_l = rq0_mul_l;
        mul_mul_h = rq0_mul_h;
        mul_clmul = rq0_clmul;
        mul_pw    = rq0_pw;
        mul_crs1  = rq0_crs1;
        mul_crs2  = rq0_crs2;
        rq0_ready = rq0_valid & mul_ready;
      end
      GNT1: begin
        mul_valid = rq1_valid;
        mul_mul_l = rq1_mul_l;
        mul_mul_h = rq1_mul_h;
        mul_clmul = rq1_clmul;
        mul_pw    = rq1_pw;
        mul_crs1  = rq1_crs1;
        mul_crs2  = rq1_crs2;
        rq1_ready = rq1_valid & mul_ready;
      end
      default: begin
        mul_valid = 1'b0;
      end
    endcase
  end

  assign rq0_result = mul_result;
  assign rq1_result = mul_result;
  assign busy       = busy_q;

endmodule

// File: tb/tb_p_mul_arbiter.sv
// Directed bench for p_mul_arbiter with a small 32-bit p_mul stub (fixed 2-cycle latency).
module tb_p_mul_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        rq0_valid, rq0_ready, rq0_mul_l, rq0_mul_h, rq0_clmul;
  logic [4:0]  rq0_pw;
  logic [31:0] rq0_crs1, rq0_crs2, rq0_result;
  logic        rq1_valid, rq1_ready, rq1_mul_l, rq1_mul_h, rq1_clmul;
  logic [4:0]  rq1_pw;
  logic [31:0] rq1_crs1, rq1_crs2, rq1_result;
  logic        mul_valid, mul_ready, mul_mul_l, mul_mul_h, mul_clmul;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1, mul_crs2, mul_result;
  logic        busy;
  logic [1:0]  lat_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;

  p_mul_arbiter dut (
    .clock(clock), .resetn(resetn),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_mul_l(rq0_mul_l), .rq0_mul_h(rq0_mul_h),
    .rq0_clmul(rq0_clmul), .rq0_pw(rq0_pw), .rq0_crs1(rq0_crs1), .rq0_crs2(rq0_crs2),
    .rq0_result(rq0_result),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_mul_l(rq1_mul_l), .rq1_mul_h(rq1_mul_h),
    .rq1_clmul(rq1_clmul), .rq1_pw(rq1_pw), .rq1_crs1(rq1_crs1), .rq1_crs2(rq1_crs2),
    .rq1_result(rq1_result),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_mul_l(mul_mul_l), .mul_mul_h(mul_mul_h),
    .mul_clmul(mul_clmul), .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2),
    .mul_result(mul_result), .busy(busy)
  );

  // p_mul stub: 32-bit lane only, ready two cycles after valid rises
  function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < 32; i++) if (b[i]) acc = acc ^ ({32'd0, a} << i);
    return acc;
  endfunction

  logic [63:0] prod;
  always_comb begin
    prod       = mul_clmul ? clmul64(mul_crs1, mul_crs2) : {32'd0, mul_crs1} * {32'd0, mul_crs2};
    mul_result = mul_mul_h ? prod[63:32] : prod[31:0];
  end
  assign mul_ready = mul_valid && (lat_cnt == 2'd2);

  always @(posedge clock or negedge resetn) begin
    if (!resetn) lat_cnt <= 2'd0;
    else if (!mul_valid || mul_ready) lat_cnt <= 2'd0;
    else lat_cnt <= lat_cnt + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int c = 0; c < 20 && who < 0; c++) begin
      step();
      if (rq0_ready && rq1_ready) who = 2;
      else if (rq0_ready) who = 0;
      else if (rq1_ready) who = 1;
    end
    if (who < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_rq(input int n, input logic ml, input logic mh, input logic cl,
                        input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      rq0_mul_l = ml; rq0_mul_h = mh; rq0_clmul = cl; rq0_pw = 5'b00001; rq0_crs1 = a; rq0_crs2 = b;
    end else begin
      rq1_mul_l = ml; rq1_mul_h = mh; rq1_clmul = cl; rq1_pw = 5'b00001; rq1_crs1 = a; rq1_crs2 = b;
    end
  endtask

  task automatic rq1_op(input string tag, input logic ml, input logic mh, input logic cl,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int who;
    set_rq(1, ml, mh, cl, a, b);
    rq1_valid = 1'b1;
    wait_grant(who);
    check({tag, "_who"}, who, 32'd1);
    check({tag, "_res"}, rq1_result, exp);
    check({tag, "_rq0_rdy"}, {31'd0, rq0_ready}, 32'd0);
    step();
    rq1_valid = 1'b0;
    step();
  endtask

  initial begin
    int who;
    int exp_who;
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    set_rq(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    set_rq(1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd6);

    // reset with both requesters valid
    step(); step();
    check("rst_mul_valid", {31'd0, mul_valid}, 32'd0);
    check("rst_rq0_ready", {31'd0, rq0_ready}, 32'd0);
    check("rst_rq1_ready", {31'd0, rq1_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    resetn = 1'b1;
    step();

    // rq0 only: 3*5 low half
    rq0_valid = 1'b1;
    step();
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_mul_valid", {31'd0, mul_valid}, 32'd1);
    check("t2_mul_crs1", mul_crs1, 32'd3);
    wait_grant(who);
    check("t2_who", who, 32'd0);
    check("t2_res", rq0_result, 32'd15);
    check("t2_rq1_rdy", {31'd0, rq1_ready}, 32'd0);
    step();
    rq0_valid = 1'b0;
    step();

    // both valid right after a fresh reset: strict alternation starting at rq0
    resetn = 1'b0; #1; resetn = 1'b1;
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef P_MUL_ARB_FIXED_PRIO_EN
      exp_who = 0;
`else
      exp_who = k % 2;
`endif
      wait_grant(who);
      check($sformatf("t3_who_%0d", k), who, exp_who);
      check($sformatf("t3_res_%0d", k), (who == 1) ? rq1_result : rq0_result,
            (exp_who == 1) ? 32'd42 : 32'd15);
      step();
      check($sformatf("t3_bubble_%0d", k), {31'd0, busy}, 32'd0);
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    step(); step();

    // rq1 only: unsigned high half, then carry-less low half
    rq1_op("t4a", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    rq1_op("t4b", 1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd5);

    // rq0 abandons its grant before ready: back to IDLE, pointer untouched
    set_rq(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    rq0_valid = 1'b1;
    step();
    check("t5_busy", {31'd0, busy}, 32'd1);
    rq0_valid = 1'b0;
    #1;
    check("t5_rq0_rdy", {31'd0, rq0_ready}, 32'd0);
    check("t5_mul_valid", {31'd0, mul_valid}, 32'd0);
    step();
    check("t5_idle", {31'd0, busy}, 32'd0);
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    wait_grant(who);
    check("t5_who_after_abort", who, 32'd0);
    step();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    step();

    // reset mid-operation in GNT1
    rq1_valid = 1'b1;
    step();
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_mul_valid", {31'd0, mul_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check("t6_rst_mul_valid", {31'd0, mul_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_rq1_rdy", {31'd0, rq1_ready}, 32'd0);
    rq0_valid = 1'b1;
    step();
    resetn = 1'b1;
    wait_grant(who);
    check("t6_who", who, 32'd0);
    check("t6_res", rq0_result, 32'd15);
    step();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
